// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing the asynchronous FIFO write port
//             among NUM_REQ producers in the write-clock domain. One
//             requester is selected per cycle. Its word is latched into a
//             single holding register, and that register drives w_en/data_in.
//             The word stays in the register until the FIFO accepts it, so
//             back-pressure from full never drops or overwrites data.
//  Macro    : WR_ARB_BURST_EN - when defined, a requester may keep the grant
//             for up to BURST_LEN consecutive words. When undefined, rotation
//             is strict after every grant.
//
//  Ports    : wclk      in   write-domain clock (rising edge)
//             wrst      in   synchronous active-high reset
//             req       in   [NUM_REQ]            level request per producer
//             req_data  in   [NUM_REQ*FIFO_WIDTH] flattened request words
//             gnt       out  [NUM_REQ]            one-hot capture strobe (comb)
//             full      in   FIFO full flag
//             w_en      out  registered FIFO write enable
//             data_in   out  [FIFO_WIDTH]         registered FIFO write data
//             wr_count  out  [16]                 accepted-write counter
//             stall     out  registered: w_en & full seen on previous edge
//
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          w_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  output logic [15:0]                   wr_count,
  output logic                          stall
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_REQ - 1);

  // Bit 0 of the state is the write enable and bit 1 is the stall flag. Both
  // outputs therefore come straight from flops. 2'b10 is unused.
  localparam logic [1:0] c_ST_IDLE  = 2'b00;
  localparam logic [1:0] c_ST_XFER  = 2'b01;
  localparam logic [1:0] c_ST_STALL = 2'b11;

  // Elaboration-time parameter sanity check.
  if (NUM_REQ < 2 || NUM_REQ > 16 || FIFO_WIDTH < 1 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_wr_arbiter: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [FIFO_WIDTH-1:0] r_data;
  logic [15:0]           r_wr_count;

  logic                  w_acc;
  logic                  w_load;
  logic                  w_found;
  logic [c_PTR_W-1:0]    w_sel;
  logic [c_PTR_W-1:0]    w_sel_inc;
  logic [c_PTR_W-1:0]    w_ptr_next;
  logic [c_PTR_W:0]      w_cand;
  logic [FIFO_WIDTH-1:0] w_req_word [NUM_REQ];

  // Split the flattened request bus into one word per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_word[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign w_en     = r_state[0];
  assign stall    = r_state[1];
  assign data_in  = r_data;
  assign wr_count = r_wr_count;

  // --------------------------------------------------------------------------
  // Accept / load qualification
  // --------------------------------------------------------------------------
  // The register can take a new word when it is empty, or when its current
  // word leaves in this same cycle. full therefore reaches gnt
  // combinationally, but it never reaches w_en or data_in.
  assign w_acc  = w_en & ~full;
  assign w_load = (~w_en | w_acc) & (|req) & ~wrst;

  // --------------------------------------------------------------------------
  // Round-robin search: first active request at or above r_rr_ptr, wrapping
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel   = r_rr_ptr;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
      if (w_cand >= (c_PTR_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (c_PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && req[w_cand[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[c_PTR_W-1:0];
      end
    end
  end

  assign w_sel_inc = (w_sel == c_LAST) ? '0 : w_sel + c_PTR_W'(1);

  always_comb begin
    gnt = '0;
    if (w_load) begin
      gnt[w_sel] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pointer advance policy
  // --------------------------------------------------------------------------
`ifdef WR_ARB_BURST_EN
  localparam int c_CNT_W = $clog2(BURST_LEN + 1);

  logic [c_CNT_W-1:0] r_burst_cnt;
  logic [c_PTR_W-1:0] r_last;
  logic [c_CNT_W-1:0] w_cnt_next;

  // A grant extends the running burst only when it goes to the same
  // requester as the last grant and the burst still has room. Any other grant
  // starts a fresh burst of one. A zero count means that no burst is in
  // progress, which is the case after reset.
  always_comb begin
    if (w_sel == r_last && r_burst_cnt != '0 &&
        r_burst_cnt < c_CNT_W'(BURST_LEN)) begin
      w_cnt_next = r_burst_cnt + c_CNT_W'(1);
    end else begin
      w_cnt_next = c_CNT_W'(1);
    end
    // The pointer stays on the owner while the burst has room. If the owner
    // drops req, the next search starting at the owner skips it anyway.
    if (w_cnt_next < c_CNT_W'(BURST_LEN)) begin
      w_ptr_next = w_sel;
    end else begin
      w_ptr_next = w_sel_inc;
    end
  end

  // The burst count moves only on loads, so stall cycles leave it unchanged.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_burst_cnt <= '0;
      r_last      <= '0;
    end else if (w_load) begin
      r_burst_cnt <= w_cnt_next;
      r_last      <= w_sel;
    end
  end
`else
  assign w_ptr_next = w_sel_inc;
`endif

  // --------------------------------------------------------------------------
  // Holding register, pointer and accepted-write counter
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_data     <= '0;
      r_rr_ptr   <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_load) begin
        r_data   <= w_req_word[w_sel];
        r_rr_ptr <= w_ptr_next;
      end
      if (w_acc) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-side FSM. The state bits drive w_en and stall directly.
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_load) begin
            r_state <= c_ST_XFER;
          end
        end
        c_ST_XFER, c_ST_STALL: begin
          // The word is occupied. While full is high it is held in place.
          // Otherwise it is accepted now, and it is refilled only if another
          // request is waiting.
          if (full) begin
            r_state <= c_ST_STALL;
          end else if (w_load) begin
            r_state <= c_ST_XFER;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter (4 x 32-bit).
//             Expected values are computed by hand in the stimulus below.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int FIFO_WIDTH = 32;
  localparam int NUM_REQ    = 4;

  logic                          wclk;
  logic                          wrst;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          full;
  logic                          w_en;
  logic [FIFO_WIDTH-1:0]         data_in;
  logic [15:0]                   wr_count;
  logic                          stall;

  int n_cmp;
  int n_err;

  fifo_wr_arbiter #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .NUM_REQ    (NUM_REQ),
    .BURST_LEN  (4)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .full     (full),
    .w_en     (w_en),
    .data_in  (data_in),
    .wr_count (wr_count),
    .stall    (stall)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    wrst     = 1'b1;
    req      = 4'b1111;
    full     = 1'b0;
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // Reset held for two edges with all requesters active.
    tick;
    tick;
    check_val("rst_gnt",   32'(gnt), 32'h0);
    check_val("rst_w_en",  32'(w_en), 32'h0);
    check_val("rst_data",  data_in, 32'h0);
    check_val("rst_count", 32'(wr_count), 32'h0);
    check_val("rst_stall", 32'(stall), 32'h0);

    // Strict rotation, one word per cycle, pointer wraps 3 -> 0.
    wrst = 1'b0;
    #1;
    for (int k = 0; k < 9; k++) begin
      check_val("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
      tick;
      check_val("rot_data",  data_in, 32'hA0 + 32'(k % 4));
      check_val("rot_w_en",  32'(w_en), 32'h1);
      check_val("rot_count", 32'(wr_count), 32'(k));
    end
    // Eight accepts done. A0 is in the register and the pointer is at 1.
    check_val("rot_gnt_a1", 32'(gnt), 32'h2);
    tick;
    check_val("bp_pre_data",  data_in, 32'hA1);
    check_val("bp_pre_count", 32'(wr_count), 32'd9);

    // Back-pressure: A1 is held for 5 cycles and no grant is issued.
    full = 1'b1;
    #1;
    check_val("bp_gnt0", 32'(gnt), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick;
      check_val("bp_data",  data_in, 32'hA1);
      check_val("bp_stall", 32'(stall), 32'h1);
      check_val("bp_w_en",  32'(w_en), 32'h1);
      check_val("bp_gnt",   32'(gnt), 32'h0);
      check_val("bp_count", 32'(wr_count), 32'd9);
    end
    full = 1'b0;
    #1;
    check_val("bp_rel_gnt", 32'(gnt), 32'h4);
    tick;
    check_val("bp_rel_count", 32'(wr_count), 32'd10);
    check_val("bp_rel_data",  data_in, 32'hA2);
    check_val("bp_rel_stall", 32'(stall), 32'h0);

    // Drain: A2 is accepted and the register empties. The pointer is at 3.
    req = 4'b0000;
    #1;
    check_val("drain_gnt", 32'(gnt), 32'h0);
    tick;
    check_val("drain_w_en",  32'(w_en), 32'h0);
    check_val("drain_count", 32'(wr_count), 32'd11);

    // Sparse requests 1010 from pointer 3: grants 3,1,3,1.
    req = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val("sp_gnt", 32'(gnt), (k % 2 == 0) ? 32'h8 : 32'h2);
      tick;
      check_val("sp_data",  data_in, (k % 2 == 0) ? 32'hA3 : 32'hA1);
      check_val("sp_count", 32'(wr_count), 32'd11 + 32'(k));
    end

    // Idle cycles with no request leave the pointer at 2.
    req = 4'b0000;
    tick;
    tick;
    tick;
    check_val("idle_w_en",  32'(w_en), 32'h0);
    check_val("idle_count", 32'(wr_count), 32'd15);
    req = 4'b1111;
    #1;
    check_val("ptr_hold_gnt", 32'(gnt), 32'h4);

    // A single active requester is granted on every cycle.
    req = 4'b0001;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_val("single_gnt", 32'(gnt), 32'h1);
      tick;
      check_val("single_data",  data_in, 32'hA0);
      check_val("single_count", 32'(wr_count), 32'd15 + 32'(k));
    end

    // Reset during a stall discards the held word.
    full = 1'b1;
    #1;
    check_val("ms_gnt", 32'(gnt), 32'h0);
    tick;
    tick;
    check_val("ms_stall", 32'(stall), 32'h1);
    check_val("ms_w_en",  32'(w_en), 32'h1);
    check_val("ms_count", 32'(wr_count), 32'd17);
    wrst = 1'b1;
    #1;
    check_val("ms_rst_gnt", 32'(gnt), 32'h0);
    tick;
    check_val("ms_rst_w_en",  32'(w_en), 32'h0);
    check_val("ms_rst_data",  data_in, 32'h0);
    check_val("ms_rst_count", 32'(wr_count), 32'h0);
    check_val("ms_rst_stall", 32'(stall), 32'h0);
    wrst = 1'b0;
    req  = 4'b0000;
    full = 1'b0;
    tick;
    tick;
    check_val("ms_post_w_en",  32'(w_en), 32'h0);
    check_val("ms_post_count", 32'(wr_count), 32'h0);

`ifdef WR_ARB_BURST_EN
    // Burst of 4 per requester, starting from pointer 0 after reset.
    req = 4'b0011;
    #1;
    for (int k = 0; k < 9; k++) begin
      check_val("burst_gnt", 32'(gnt), ((k % 8) < 4) ? 32'h1 : 32'h2);
      tick;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the asynchronous FIFO's write port among `NUM_REQ` producers in the write-clock domain. It selects one requester per cycle and latches its word into a single output holding register that drives `w_en`/`data_in`. The register holds each word until the FIFO accepts it, so back-pressure from `full` is absorbed without dropping data. The block sits between the producer agents and the FIFO write side and uses only `wclk`.

## Interface
- `FIFO_WIDTH`, 32, data word width; must match the FIFO.
- `NUM_REQ`, 4, number of requesters (2..16).
- `BURST_LEN`, 4, maximum consecutive grants to one requester. Used only with burst mode (see Configuration).
- `wclk` in 1: write-domain clock; all logic on its rising edge.
- `wrst` in 1: reset, synchronous, active-high.
- `req` in NUM_REQ: per-requester write request; level, held until granted.
- `req_data` in NUM_REQ*FIFO_WIDTH: flattened request words; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `gnt` out NUM_REQ: one-hot, combinational. Asserted for one cycle when requester i's word is captured. The requester drops or advances `req`/data on the following edge.
- `full` in 1: FIFO full flag, write domain.
- `w_en` out 1: registered FIFO write enable; high while the holding register is occupied.
- `data_in` out FIFO_WIDTH: registered FIFO write data.
- `wr_count` out 16: accepted-write counter; wraps 0xFFFF→0.
- `stall` out 1: registered; high when `w_en`=1 and `full`=1 on the previous edge.

## Operation
- Accept condition: `acc` = `w_en` & !`full`. The FIFO takes `data_in` on the edge where `acc`=1.
- Load condition: `load` = (!`w_en` | `acc`) & (|`req`) & !`wrst`. A new word can enter only when the register is empty or being vacated in the same cycle.
- Selection: the first requester with `req`=1, searched upward from `rr_ptr` modulo NUM_REQ. `gnt[sel]`=`load`.
- On `load`:
  - `data_in`←`req_data[sel]`; `w_en`←1.
  - `rr_ptr`←(sel+1) mod NUM_REQ. Burst mode modifies this rule (see Configuration).
- On `acc` & !`load`: `w_en`←0.
- On `acc`: `wr_count`←`wr_count`+1.
- FSM states:
  - IDLE (`w_en`=0).
  - XFER (`w_en`=1, `full`=0).
  - STALL (`w_en`=1, `full`=1).
- Transitions:
  - IDLE→XFER on `load`.
  - XFER→XFER on `acc`&`load`; XFER→IDLE on `acc`&!`load`; XFER→STALL on `full`.
  - STALL→XFER when `full` falls. The held word is presented unchanged and `gnt` stays 0 while in STALL.
- Boundaries:
  - `full` rising while `w_en`=1: the word is retained, never overwritten or lost.
  - All `req`=0: `rr_ptr` is unchanged.
  - Single requester active: it is granted every accept cycle.
  - `rr_ptr` wraps NUM_REQ-1→0.
- Reset: when `wrst`=1 at an edge:
  - `w_en`=0, `data_in`=0, `rr_ptr`=0, burst count=0, `wr_count`=0, `stall`=0, state=IDLE.
  - `gnt`=0 while `wrst`=1.
  - A word pending in the register is discarded. Mid-stall reset is legal.

## Timing
- `gnt` in cycle t → `w_en`/`data_in` valid from edge t+1.
- FIFO acceptance is no earlier than edge t+2 when `full`=0.
- Sustained throughput is one word per `wclk` with `full`=0.
- `stall` lags `full` by one cycle.
- `wr_count` updates on the accept edge.
- No combinational path from `full` to `w_en` or `data_in`. The `full`→`gnt` path is combinational.

## Configuration
- `WR_ARB_BURST_EN` defined:
  - After granting i, `rr_ptr` stays at i while `req[i]`=1 and the burst count is below BURST_LEN.
  - The burst count resets to 1 on a grant to a different requester.
  - When the count reaches BURST_LEN, or `req[i]` drops, `rr_ptr`←(i+1) mod NUM_REQ.
  - A stall does not advance the count.
- Not defined: strict rotation after every grant; the burst count and BURST_LEN logic are absent.

## Test plan
- Reset: assert `wrst` 2 cycles with `req`=4'b1111 → `gnt`=0, `w_en`=0, `data_in`=0, `wr_count`=0. After release, first grant goes to requester 0.
- Rotation (burst off): `req`=4'b1111 held, data i=0xA0+i, `full`=0 → `data_in` sequence A0,A1,A2,A3,A0…; one write per cycle; `wr_count`=8 after 8 accepts.
- Back-pressure: `full`=1 for 5 cycles while `w_en`=1 with 0xA1 → `data_in` stays 0xA1, `gnt`=0, `stall`=1. On release, 0xA1 is written exactly once and `wr_count`+1.
- Sparse requests: `req`=4'b1010 → grants alternate 1,3,1,3; `rr_ptr` skips 0 and 2.
- Burst (`WR_ARB_BURST_EN`, BURST_LEN=4): `req`=4'b0011 → grants 0,0,0,0,1,1,1,1,0…; dropping `req[0]` after 2 grants moves to requester 1 immediately.
- Reset mid-stall: `w_en`=1, `full`=1, then `wrst` pulse → word discarded, `w_en`=0. No FIFO write occurs when `full` later falls.
